// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional checksum stage is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;
  localparam int LANE_WIDTH     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave side; the stream source / memory model take master.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/prog_loader_packer.sv
// Little-endian byte-to-word assembler: lane byte_cnt receives each byte and the
// completed word is presented with a one-cycle word_valid the cycle after its 4th byte.
module byte_to_word_packer
  import prog_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic [LANE_WIDTH-1:0] byte_cnt,
  output logic                  word_valid,
  output logic [31:0]           word_data
);

  logic [LANE_WIDTH-1:0] byte_cnt_reg;
  logic [7:0]            lane_reg [BYTES_PER_WORD-1];
  logic [31:0]           word_next;
  logic                  word_last;
  logic                  word_valid_reg;
  logic [31:0]           word_data_reg;

  assign word_last = byte_en && (byte_cnt_reg == LANE_WIDTH'(BYTES_PER_WORD - 1));

  // The top lane is never stored: it is taken straight from the bus on the closing byte.
  assign word_next[8*BYTES_PER_WORD-1 -: 8] = byte_data;

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = lane_reg[gi];

      always_ff @(posedge clock) begin
        if (reset || clear) begin
          lane_reg[gi] <= '0;
        end else if (byte_en && (byte_cnt_reg == LANE_WIDTH'(gi))) begin
          lane_reg[gi] <= byte_data;
        end
      end
    end
  endgenerate

  // clear only rewinds assembly; a write already scheduled still goes out.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_reg   <= '0;
      word_valid_reg <= 1'b0;
      word_data_reg  <= '0;
    end else begin
      word_valid_reg <= word_last;
      if (word_last) begin
        word_data_reg <= word_next;
      end
      if (clear) begin
        byte_cnt_reg <= '0;
      end else if (byte_en) begin
        byte_cnt_reg <= byte_cnt_reg + LANE_WIDTH'(1);
      end
    end
  end

  assign byte_cnt   = byte_cnt_reg;
  assign word_valid = word_valid_reg;
  assign word_data  = word_data_reg;

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: length-prefixed byte stream -> instruction memory words, holding
// the CPU in reset until the image is complete. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_WORDS  = 256,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  localparam int                   WCNT_WIDTH = $clog2(MAX_WORDS + 1);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN    = LEN_WIDTH'(MAX_WORDS);

  state_t                  state_reg, state_next;
  logic [LEN_WIDTH-1:0]    length_reg;
  logic [LEN_WIDTH-1:0]    len_full;
  logic [WCNT_WIDTH-1:0]   word_cnt_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic                    in_ready_reg, in_ready_next;
  logic                    done_reg, done_next;
  logic                    error_reg, error_next;
  logic                    cpu_reset_reg, cpu_reset_next;

  logic                    accept;
  logic                    len_lo_we;
  logic                    len_hi_we;
  logic                    data_byte_en;
  logic                    cnt_clear;
  logic                    word_done;
  logic                    last_word;
  logic [LANE_WIDTH-1:0]   byte_cnt;
  logic                    word_valid;
  logic [31:0]             word_data;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]              xor_reg;
`endif

  assign accept    = bus.in_valid && in_ready_reg;
  assign len_full  = {bus.in_data, length_reg[7:0]};
  assign word_done = data_byte_en && (byte_cnt == LANE_WIDTH'(BYTES_PER_WORD - 1));
  assign last_word = (LEN_WIDTH'(word_cnt_reg) == (length_reg - LEN_WIDTH'(1)));

  byte_to_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .byte_en    (data_byte_en),
    .byte_data  (bus.in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LEN_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    len_lo_we    = 1'b0;
    len_hi_we    = 1'b0;
    data_byte_en = 1'b0;
    cnt_clear    = 1'b0;

    case (state_reg)
      LEN_LO: begin
        if (accept) begin
          len_lo_we  = 1'b1;
          state_next = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_hi_we = 1'b1;
          cnt_clear = 1'b1;
          if ((len_full == '0) || (len_full > MAX_LEN)) begin
            state_next = ERROR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          data_byte_en = 1'b1;
          if (word_done && last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = DONE;
`endif
          end
        end
      end
      CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept) begin
          state_next = (bus.in_data == xor_reg) ? DONE : ERROR;
        end
`else
        state_next = LEN_LO;
`endif
      end
      DONE, ERROR: begin
        if (start) begin
          state_next = LEN_LO;
          cnt_clear  = 1'b1;
        end
      end
      default: state_next = LEN_LO;
    endcase

    // in_ready decodes the upcoming state so it is never high in DONE/ERROR.
    in_ready_next  = (state_next != DONE) && (state_next != ERROR);
    done_next      = (state_reg == DONE) && !start;
    error_next     = (state_reg == ERROR) && !start;
    cpu_reset_next = !done_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      length_reg    <= '0;
      word_cnt_reg  <= '0;
      mem_addr_reg  <= '0;
      in_ready_reg  <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      cpu_reset_reg <= 1'b1;
    end else begin
      in_ready_reg  <= in_ready_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      cpu_reset_reg <= cpu_reset_next;
      if (len_lo_we) begin
        length_reg[7:0] <= bus.in_data;
      end
      if (len_hi_we) begin
        length_reg[LEN_WIDTH-1:8] <= bus.in_data;
      end
      // Address is latched with the closing byte so it lines up with the packer's write pulse.
      if (cnt_clear) begin
        word_cnt_reg <= '0;
      end else if (word_done) begin
        word_cnt_reg <= word_cnt_reg + WCNT_WIDTH'(1);
        mem_addr_reg <= ADDR_WIDTH'({word_cnt_reg, 2'b00});
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || cnt_clear) begin
      xor_reg <= '0;
    end else if (data_byte_en) begin
      xor_reg <= xor_reg ^ bus.in_data;
    end
  end
`endif

  assign bus.in_ready  = in_ready_reg;
  assign bus.mem_we    = word_valid;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = word_data;
  assign cpu_reset     = cpu_reset_reg;
  assign done          = done_reg;
  assign error         = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal, length boundaries, gaps, restart, mid-load reset
// and (with PROG_LOADER_CHECKSUM_EN) checksum match/mismatch.
module tb_prog_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset;
  logic done;
  logic error;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int we_wide = 0;
  logic prev_we = 1'b0;

  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int NOM_CYCLES = 11;
`else
  localparam int NOM_CYCLES = 10;
`endif

  prog_loader_if #(.ADDR_WIDTH(10)) bus ();

  prog_loader #(.MAX_WORDS(256), .ADDR_WIDTH(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory-side monitor: logs every write and flags write pulses longer than one cycle.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      if (prev_we === 1'b1) we_wide <= we_wide + 1;
      $display("write addr=%0h data=%08h", bus.mem_addr, bus.mem_wdata);
    end
    prev_we <= bus.mem_we;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b required 1 (byte %02h)", bus.in_ready, b);
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    start = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    we_wide = 0;
  endtask

  task automatic load_nominal(input int gap_max);
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 10'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    $display("test_reset: reset values sampled");
  endtask

  task automatic test_nominal();
    int c0;
    do_reset();
    c0 = cyc;
    load_nominal(0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hB0, 0);
`endif
    checks++; if (cyc - c0 !== NOM_CYCLES) begin fails++; $display("FAIL nom_full_rate: got %0d cycles want %0d", cyc - c0, NOM_CYCLES); end
    checks++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin fails++; $display("FAIL nom_entry_cycle: done=%b cpu_reset=%b want 0/1", done, cpu_reset); end
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL nom_in_ready: got %b want 0", bus.in_ready); end
    idle(1);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin fails++; $display("FAIL nom_done: done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
    idle(2);
    checks++;
    if (wr_addr_q.size() != 2) begin
      fails++; $display("FAIL nom_write_count: got %0d want 2", wr_addr_q.size());
    end else begin
      if (wr_addr_q[0] !== 10'h0 || wr_data_q[0] !== 32'h00100513) begin fails++; $display("FAIL nom_word0: got %h@%h want 00100513@0", wr_data_q[0], wr_addr_q[0]); end
      checks++;
      if (wr_addr_q[1] !== 10'h4 || wr_data_q[1] !== 32'h00200593) begin fails++; $display("FAIL nom_word1: got %h@%h want 00200593@4", wr_data_q[1], wr_addr_q[1]); end
    end
    checks++; if (we_wide !== 0) begin fails++; $display("FAIL nom_we_width: %0d wide pulses want 0", we_wide); end
    $display("test_nominal: %0d writes", wr_addr_q.size());
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle(1);
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL zero_error: got %b want 1", error); end
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_cpu_reset: cpu_reset=%b done=%b want 1/0", cpu_reset, done); end
    checks++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_addr_q.size()); end
    start = 1'b1;
    idle(1);
    start = 1'b0;
    checks++; if (error !== 1'b0 || bus.in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      fails++; $display("FAIL zero_restart: error=%b in_ready=%b cpu_reset=%b want 0/1/1", error, bus.in_ready, cpu_reset);
    end
    $display("test_zero_len: error then restart");
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL over_in_ready: got %b want 0", bus.in_ready); end
    idle(1);
    checks++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin fails++; $display("FAIL over_error: error=%b cpu_reset=%b want 1/1", error, cpu_reset); end
    checks++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL over_writes: got %0d want 0", wr_addr_q.size()); end
    // Exactly MAX_WORDS is legal.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    idle(2);
    checks++; if (error !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL max_accepted: error=%b in_ready=%b want 0/1", error, bus.in_ready); end
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    idle(2);
    checks++;
    if (wr_addr_q.size() != 1) begin
      fails++; $display("FAIL max_write_count: got %0d want 1", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 10'h0 || wr_data_q[0] !== 32'h12345678) begin
      fails++; $display("FAIL max_word0: got %h@%h want 12345678@0", wr_data_q[0], wr_addr_q[0]);
    end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL max_not_done: got %b want 0", done); end
    $display("test_oversize: 0x0101 rejected, 0x0100 accepted");
  endtask

  task automatic test_gapped();
    do_reset();
    load_nominal(3);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hB0, 2);
`endif
    idle(3);
    checks++;
    if (wr_addr_q.size() != 2) begin
      fails++; $display("FAIL gap_write_count: got %0d want 2", wr_addr_q.size());
    end else begin
      if (wr_addr_q[0] !== 10'h0 || wr_data_q[0] !== 32'h00100513) begin fails++; $display("FAIL gap_word0: got %h@%h want 00100513@0", wr_data_q[0], wr_addr_q[0]); end
      checks++;
      if (wr_addr_q[1] !== 10'h4 || wr_data_q[1] !== 32'h00200593) begin fails++; $display("FAIL gap_word1: got %h@%h want 00200593@4", wr_data_q[1], wr_addr_q[1]); end
    end
    checks++; if (we_wide !== 0) begin fails++; $display("FAIL gap_we_width: %0d wide pulses want 0", we_wide); end
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin fails++; $display("FAIL gap_done: done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
    $display("test_gapped: %0d writes", wr_addr_q.size());
  endtask

  task automatic test_restart();
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    checks++; if (done !== 1'b0 || cpu_reset !== 1'b1 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL restart_clear: done=%b cpu_reset=%b in_ready=%b want 0/1/1", done, cpu_reset, bus.in_ready);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h22, 0);
`endif
    idle(2);
    checks++;
    if (wr_addr_q.size() != 1) begin
      fails++; $display("FAIL restart_write_count: got %0d want 1", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 10'h0 || wr_data_q[0] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL restart_word0: got %h@%h want deadbeef@0", wr_data_q[0], wr_addr_q[0]);
    end
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin fails++; $display("FAIL restart_done: done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
    $display("test_restart: 1-word image reloaded");
  endtask

  task automatic test_midload_reset();
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    checks++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL midrst_writes: got %0d want 0", wr_addr_q.size()); end
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_state: cpu_reset=%b done=%b in_ready=%b want 1/0/1", cpu_reset, done, bus.in_ready);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h44, 0);
`endif
    idle(2);
    checks++;
    if (wr_addr_q.size() != 1) begin
      fails++; $display("FAIL midrst_write_count: got %0d want 1", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 10'h0 || wr_data_q[0] !== 32'h11223344) begin
      fails++; $display("FAIL midrst_word0: got %h@%h want 11223344@0", wr_data_q[0], wr_addr_q[0]);
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL midrst_done: got %b want 1", done); end
    $display("test_midload_reset: reload after reset");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    do_reset();
    load_nominal(0);
    send_byte(8'hB1, 0);
    idle(2);
    checks++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL chk_bad: error=%b cpu_reset=%b done=%b want 1/1/0", error, cpu_reset, done);
    end
    checks++; if (wr_addr_q.size() != 2) begin fails++; $display("FAIL chk_bad_writes: got %0d want 2", wr_addr_q.size()); end
    $display("test_checksum_bad: mismatch rejected");
  endtask
`endif

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_nominal();
    test_zero_len();
    test_oversize();
    test_gapped();
    test_restart();
    test_midload_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
